// File: rtl/rx_byte_assembler_if.sv
// rtl/rx_byte_assembler_if.sv - received-byte handshake bundle between assembler and consumer
interface rx_byte_assembler_if #(
    parameter int DATA_BITS = 8
);
    logic [DATA_BITS-1:0] rx_data;
    logic                 data_ready;
    logic                 data_read;
    logic                 framing_error;
    logic                 overrun_error;

    modport master (
        output rx_data,
        output data_ready,
        output framing_error,
        output overrun_error,
        input  data_read
    );

    modport slave (
        input  rx_data,
        input  data_ready,
        input  framing_error,
        input  overrun_error,
        output data_read
    );
endinterface

// File: rtl/rx_byte_assembler.sv
// rtl/rx_byte_assembler.sv - serial frame receiver: start detect, LSB-first shift, stop check, ready/read handshake
module rx_byte_assembler #(
    parameter int DATA_BITS = 8
) (
    input  logic clk,
    input  logic n_rst,
    input  logic serial_in,
    input  logic bit_strobe,
    output logic div_enable,
    rx_byte_assembler_if.master rx
);
    localparam int CW = $clog2(DATA_BITS + 1);

    typedef enum logic [2:0] {
        IDLE,
        START,
        DATA,
        STOP,
        LOAD
    } state_t;

    state_t               state_q;
    state_t               state_d;
    logic                 sync1;
    logic                 s_in;
    logic                 s_prev;
    logic [DATA_BITS-1:0] shift_q;
    logic [DATA_BITS-1:0] shift_next;
    logic [CW-1:0]        bit_cnt_q;
    logic                 stop_bad_q;
    logic [DATA_BITS-1:0] rx_data_q;
    logic                 data_ready_q;
    logic                 framing_error_q;
    logic                 overrun_error_q;

    assign rx.rx_data       = rx_data_q;
    assign rx.data_ready    = data_ready_q;
    assign rx.framing_error = framing_error_q;
    assign rx.overrun_error = overrun_error_q;

    // New bit enters at the MSB so the first bit received ends up in bit 0.
    generate
        if (DATA_BITS == 1) begin : g_shift_one
            assign shift_next = s_in;
        end else begin : g_shift_many
            assign shift_next = {s_in, shift_q[DATA_BITS-1:1]};
        end
    endgenerate

    // Two-flop synchroniser plus a history flop; resets to idle-high so reset release cannot look like a start.
    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            sync1  <= 1'b1;
            s_in   <= 1'b1;
            s_prev <= 1'b1;
        end else begin
            sync1  <= serial_in;
            s_in   <= sync1;
            s_prev <= s_in;
        end
    end

    // State register.
    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state and Moore divider enable; strobes only matter while the divider runs.
    always_comb begin
        state_d    = state_q;
        div_enable = 1'b0;
        case (state_q)
            IDLE: begin
                if (s_prev && !s_in) begin
                    state_d = START;
                end
            end
            START: begin
                div_enable = 1'b1;
                if (bit_strobe) begin
                    state_d = s_in ? IDLE : DATA;
                end
            end
            DATA: begin
                div_enable = 1'b1;
                if (bit_strobe && (bit_cnt_q == CW'(DATA_BITS - 1))) begin
                    state_d = STOP;
                end
            end
            STOP: begin
                div_enable = 1'b1;
                if (bit_strobe) begin
                    state_d = LOAD;
                end
            end
            LOAD: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // Frame datapath: bit counter, shift register and stop-bit capture.
    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            shift_q    <= '0;
            bit_cnt_q  <= '0;
            stop_bad_q <= 1'b0;
        end else begin
            if (state_q == IDLE && state_d == START) begin
                bit_cnt_q <= '0;
            end
            if (state_q == DATA && bit_strobe) begin
                shift_q   <= shift_next;
                bit_cnt_q <= bit_cnt_q + CW'(1);
            end
            if (state_q == STOP && bit_strobe) begin
                stop_bad_q <= ~s_in;
            end
        end
    end

    // Consumer-facing registers: LOAD publishes the frame and takes priority over a coincident read.
    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            rx_data_q       <= '0;
            data_ready_q    <= 1'b0;
            framing_error_q <= 1'b0;
            overrun_error_q <= 1'b0;
        end else if (state_q == LOAD) begin
            rx_data_q       <= shift_q;
            framing_error_q <= stop_bad_q;
            data_ready_q    <= 1'b1;
            if (data_ready_q && !rx.data_read) begin
                overrun_error_q <= 1'b1;
            end
        end else if (rx.data_read) begin
            data_ready_q    <= 1'b0;
            overrun_error_q <= 1'b0;
        end
    end
endmodule

// File: doc/rx_byte_assembler.md
Name: rx_byte_assembler

Overview:
- Serial receive stage directly downstream of the 8-clock bit-strobe divider (`clockdivider`).
- Detects a start bit on the synchronised serial line and enables the divider.
- Uses each divider `flag_pulse` as the bit-sample strobe.
- Shifts in DATA_BITS bits LSB-first, checks the stop bit, and presents the byte with a ready/read handshake plus framing and overrun flags.

Parameters:
- DATA_BITS, 8, number of data bits per frame (range 1..16).

Ports:
- clk  in  1  system clock.
- n_rst  in  1  asynchronous, active-low reset.
- serial_in  in  1  raw serial line; idles high; asynchronous to clk.
- bit_strobe  in  1  sample strobe, driven by the divider's `flag_pulse`; one clk wide.
- data_read  in  1  consumer acknowledge; one-cycle pulse.
- div_enable  out  1  drives the divider `enable`; high while a frame is in progress.
- rx_data  out  DATA_BITS  last received byte; held until the next frame loads.
- data_ready  out  1  rx_data holds an unread frame.
- framing_error  out  1  stop bit of the last loaded frame sampled low.
- overrun_error  out  1  a frame was loaded while the previous frame was still unread.

Behaviour:
- Reset (async, n_rst low): all flops clear immediately.
  - state=IDLE, rx_data=0, data_ready=0, framing_error=0, overrun_error=0.
  - Shift register and bit counter =0.
  - Both synchroniser flops =1, i.e. idle line. This prevents a false start right after reset.
- Reset mid-frame aborts the frame. No partial data reaches rx_data.
- Input synchroniser:
  - serial_in passes through 2 flops → s_in.
  - A third flop holds s_prev.
  - Falling edge = s_prev==1 && s_in==0.
- Clock domain rule: all logic samples s_in, never serial_in.
- div_enable is a Moore output: 1 in START, DATA, STOP; 0 in IDLE, LOAD.
- bit_strobe is ignored in IDLE and LOAD.
- FSM states:
  - IDLE: on falling edge → START; clear bit counter.
  - START, on bit_strobe:
    - If s_in==0 (valid start) → DATA.
    - If s_in==1 (glitch) → IDLE. No flags change.
  - DATA, on bit_strobe:
    - Shift register ← {s_in, shift[DATA_BITS-1:1]}, LSB-first.
    - bit counter +1.
    - On the strobe that brings the counter to DATA_BITS → STOP.
  - STOP, on bit_strobe: latch stop_bad = ~s_in → LOAD.
  - LOAD (exactly 1 cycle), then → IDLE unconditionally:
    - rx_data ← shift register.
    - framing_error ← stop_bad.
    - data_ready ← 1.
    - overrun_error ← 1 if data_ready==1 && data_read==0 this cycle; otherwise it holds its value.
- Handshake:
  - data_read in any state other than LOAD clears data_ready and overrun_error the next cycle.
  - data_read coincident with LOAD: the new frame wins. data_ready stays 1 and overrun is not set, because the old frame counts as read.
  - data_read while data_ready==0 has no effect.
- framing_error changes only in LOAD; it is not cleared by data_read.
- A frame with a framing error still loads rx_data and sets data_ready.
- Back-to-back frames:
  - A falling edge seen during LOAD is lost; a new start is accepted from IDLE onwards.
  - s_prev/s_in are sampled continuously, so the edge condition needs s_prev==1 while in IDLE.
- Bit counter width: $clog2(DATA_BITS+1). It never wraps; it is cleared on IDLE→START.
- Latency: data_ready rises 2 clk after the STOP-state strobe (STOP→LOAD transition, then LOAD registers the outputs).

Test Plan:
- Setup for all tests: divider model with strobe every 8 clk while div_enable=1.
  1. Reset check: reset asserted mid-frame → all outputs 0 asynchronously; no data_ready after release with the line held high.
  2. Frame 0xA5 with a valid stop, sent LSB-first (1,0,1,0,0,1,0,1) at 8 clk/bit → rx_data=0xA5, data_ready=1, framing_error=0, div_enable low after STOP.
  3. Frame 0x3C with stop bit low → rx_data=0x3C, framing_error=1, data_ready=1. A following good frame 0x01 clears framing_error to 0.
  4. Overrun: send 0x11, no read, then send 0x22 → rx_data=0x22, overrun_error=1. Pulse data_read → data_ready=0 and overrun_error=0 next cycle.
  5. Glitch start: line low for 3 clk then high before the first strobe → return to IDLE, data_ready stays 0, rx_data unchanged.
  6. Coincident read: data_read pulsed exactly in the LOAD cycle of a second frame 0x7E → data_ready=1, overrun_error=0, rx_data=0x7E.
